sprite_rom_arbiter: RTL



---
 rtl/sprite_arb_pkg.sv | 27 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 33 +++
 rtl/sprite_rom_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Build option: SPRITE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package sprite_arb_pkg;

    localparam int SPRITE_SIDE = 64;
    localparam int SPRITE_AW   = $clog2(SPRITE_SIDE * SPRITE_SIDE);
    localparam int PIX_DW      = 16;

    // Tags are sized for the largest supported requester count.
    localparam int MAX_REQ = 16;
    localparam int IDW     = $clog2(MAX_REQ);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } rd_tag_t;

    function automatic logic [IDW-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo N.
// Unused when SPRITE_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            for (int k = 0; k < N; k++) begin
                if (!found && (cand == k) && req[k]) begin
                    found  = 1'b1;
                    gnt[k] = 1'b1;
                    idx    = PW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between N_REQ requesters and routes read data back.
// Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int AW      = SPRITE_AW,
    parameter int DW      = PIX_DW,
    parameter int ROM_LAT = 1
) (
    input  logic                         vga_clk,
    input  logic                         arst_n,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ*AW-1:0]          addr_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic                         rom_en_o,
    output logic [$clog2(N_REQ)+AW-1:0]  rom_addr_o,
    input  logic [DW-1:0]                rom_data_i,
    output logic [N_REQ-1:0]             rvalid_o,
    output logic [DW-1:0]                rdata_o
);

    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic [N_REQ-1:0] gnt;
    logic [AW-1:0]    sel_addr;

    rd_tag_t          tag_q [ROM_LAT];
    rd_tag_t          tag_d [ROM_LAT];
    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_gnt = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) pick_gnt = N_REQ'(1) << i;
        end
        pick_idx = PW'(onehot2idx(MAX_REQ'(pick_gnt)));
    end
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|gnt) begin
            rr_ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Grants are suppressed while reset is held so the ROM sees no reads.
    assign gnt      = arst_n ? pick_gnt : '0;
    assign gnt_o    = gnt;
    assign rom_en_o = |gnt;

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == PW'(k)) sel_addr = addr_i[k*AW +: AW];
        end
        rom_addr_o = rom_en_o ? {pick_idx, sel_addr} : '0;
    end

    always_comb begin
        tag_d[0].valid = rom_en_o;
        tag_d[0].id    = IDW'(pick_idx);
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The tag leaving the pipe lines up with the ROM word for the same grant.
    always_comb begin
        rvalid_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rvalid_d[k] = tag_q[ROM_LAT-1].valid && (tag_q[ROM_LAT-1].id == IDW'(k));
        end
        rdata_d = tag_q[ROM_LAT-1].valid ? rom_data_i : rdata_q;
    end

    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= tag_d[i];
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule
